// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state codes, default bubble counts and counter helpers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_e;

    localparam int unsigned DEF_STALL_CYCLES = 1;
    localparam int unsigned DEF_FLUSH_CYCLES = 1;
    localparam int unsigned CNT_W            = 3;

    // Counter preload: the request cycle itself is the first bubble.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/halt controller (Mealy outputs, 3-bit bubble counter).
// Define PIPE_STALL_PERF_EN to add the saturating stall_cnt output.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_stall,
    input  logic        ifid_stall,
    input  logic        br_taken,
    input  logic        hlt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_nop,
`ifdef PIPE_STALL_PERF_EN
    output logic [15:0] stall_cnt,
`endif
    output logic [1:0]  state_o
);

    localparam logic [CNT_W-1:0] STALL_LD = cnt_load(STALL_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LD = cnt_load(FLUSH_CYCLES);

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_req;
    logic             w_last;

    assign w_req   = pc_stall | ifid_stall;
    assign w_last  = (r_cnt <= CNT_W'(1));
    assign state_o = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_nop    = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_nop    = 1'b1;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (hlt || r_state == ST_HALT) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_nop    = 1'b1;
            w_state_nxt = ST_HALT;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_RUN, ST_STALL: begin
                    if (br_taken) begin
                        // Branch wins; any pending stall count is dropped.
                        ifid_flush  = 1'b1;
                        idex_nop    = 1'b1;
                        w_cnt_nxt   = FLUSH_LD;
                        w_state_nxt = (FLUSH_LD != '0) ? ST_FLUSH : ST_RUN;
                    end else if (r_state == ST_STALL) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_nop    = 1'b1;
                        w_cnt_nxt   = w_last ? '0 : r_cnt - CNT_W'(1);
                        w_state_nxt = w_last ? ST_RUN : ST_STALL;
                    end else if (w_req) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_nop    = 1'b1;
                        w_cnt_nxt   = STALL_LD;
                        w_state_nxt = (STALL_LD != '0) ? ST_STALL : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_nop    = 1'b1;
                    w_cnt_nxt   = w_last ? '0 : r_cnt - CNT_W'(1);
                    w_state_nxt = w_last ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    w_state_nxt = ST_HALT;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
